// File: rtl/sap_seq_vlen_if.sv
// Control bundle between the variable-length sequencer and the SAP datapath.
// master = sequencer side (drives strobes), slave = datapath side.
interface sap_seq_vlen_if #(
    parameter int OPCODE_W = 4,
    parameter int T_W      = 4
);
    logic [OPCODE_W-1:0] op_code;
    logic                mem_rdy;
    logic                step_mode;
    logic                step_req;

    logic                inc;
    logic                pc_out_en;
    logic                low_ld_mar;
    logic                low_mem_out_en;
    logic                low_mem_wr;
    logic                low_ld_ir;
    logic                low_ir_out_en;
    logic                low_ld_acc;
    logic                acc_out_en;
    logic                low_ld_b_reg;
    logic                alu_out_en;
    logic [2:0]          alu_op;
    logic                low_ld_flags;
    logic                low_ld_out_reg;
    logic                low_halt;
    logic [T_W-1:0]      t_state;
    logic                instr_done;

    modport master (
        input  op_code, mem_rdy, step_mode, step_req,
        output inc, pc_out_en, low_ld_mar, low_mem_out_en, low_mem_wr, low_ld_ir,
               low_ir_out_en, low_ld_acc, acc_out_en, low_ld_b_reg, alu_out_en,
               alu_op, low_ld_flags, low_ld_out_reg, low_halt, t_state, instr_done
    );

    modport slave (
        output op_code, mem_rdy, step_mode, step_req,
        input  inc, pc_out_en, low_ld_mar, low_mem_out_en, low_mem_wr, low_ld_ir,
               low_ir_out_en, low_ld_acc, acc_out_en, low_ld_b_reg, alu_out_en,
               alu_op, low_ld_flags, low_ld_out_reg, low_halt, t_state, instr_done
    );
endinterface

// File: rtl/sap_seq_vlen.sv
// Variable-length SAP control sequencer: shared 3-state fetch, per-opcode execute, step/halt.
// Latency: strobes are combinational from state + op_code; they take effect at the edge ending each T state.
// Backpressure: mem_rdy=0 in a memory-access state holds the state and masks load/inc/write strobes.
module sap_seq_vlen #(
    parameter int OPCODE_W = 4,
    parameter int T_MAX    = 6,
    parameter int T_W      = 4
) (
    input  logic           clk,
    input  logic           low_clr,
    sap_seq_vlen_if.master bus
);
    typedef enum logic [T_W-1:0] {
        S_WAIT = T_W'(0),
        S_T1   = T_W'(1),
        S_T2   = T_W'(2),
        S_T3   = T_W'(3),
        S_T4   = T_W'(4),
        S_T5   = T_W'(5),
        S_T6   = T_W'(6)
    } state_t;

    state_t state_q, state_d;
    logic   halt_q, halt_d;

    logic [3:0] op;
    logic [3:0] op_m1;
    logic       op_ok;

    // Opcodes with any upper bit set decode as NOP.
    generate
        if (OPCODE_W > 4) begin : g_wide_op
            assign op_ok = (bus.op_code[OPCODE_W-1:4] == '0);
        end else begin : g_narrow_op
            assign op_ok = 1'b1;
        end
    endgenerate

    assign op    = op_ok ? bus.op_code[3:0] : 4'h9;
    assign op_m1 = op - 4'd1;

    logic d_inc, d_pc_out, d_ld_mar, d_mem_out, d_mem_wr, d_ld_ir, d_ir_out;
    logic d_ld_acc, d_acc_out, d_ld_b, d_alu_out, d_ld_flags, d_ld_out;
    logic [2:0] d_alu_op;
    logic last, hlt_t4, orphan, stall, en;

    always_ff @(posedge clk or negedge low_clr) begin
        if (!low_clr) begin
            state_q <= S_T1;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        d_inc      = 1'b0;
        d_pc_out   = 1'b0;
        d_ld_mar   = 1'b0;
        d_mem_out  = 1'b0;
        d_mem_wr   = 1'b0;
        d_ld_ir    = 1'b0;
        d_ir_out   = 1'b0;
        d_ld_acc   = 1'b0;
        d_acc_out  = 1'b0;
        d_ld_b     = 1'b0;
        d_alu_out  = 1'b0;
        d_ld_flags = 1'b0;
        d_ld_out   = 1'b0;
        d_alu_op   = 3'b000;
        last       = 1'b0;
        hlt_t4     = 1'b0;
        orphan     = 1'b0;

        if (!halt_q) begin
            case (state_q)
                S_WAIT: ;
                S_T1: begin
                    d_pc_out = 1'b1;
                    d_ld_mar = 1'b1;
                end
                S_T2: d_inc = 1'b1;
                S_T3: begin
                    d_mem_out = 1'b1;
                    d_ld_ir   = 1'b1;
                    case (op)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                        4'h7, 4'h8, 4'hE, 4'hF: ;
                        default: last = 1'b1;
                    endcase
                end
                S_T4: begin
                    case (op)
                        4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8: begin
                            d_ir_out = 1'b1;
                            d_ld_mar = 1'b1;
                        end
                        4'h7: begin
                            d_ir_out = 1'b1;
                            d_ld_acc = 1'b1;
                            last     = 1'b1;
                        end
                        4'hE: begin
                            d_acc_out = 1'b1;
                            d_ld_out  = 1'b1;
                            last      = 1'b1;
                        end
                        4'hF:    hlt_t4 = 1'b1;
                        default: orphan = 1'b1;
                    endcase
                end
                S_T5: begin
                    case (op)
                        4'h0: begin
                            d_mem_out = 1'b1;
                            d_ld_acc  = 1'b1;
                            last      = 1'b1;
                        end
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                            d_mem_out = 1'b1;
                            d_ld_b    = 1'b1;
                        end
                        4'h8: begin
                            d_acc_out = 1'b1;
                            d_mem_wr  = 1'b1;
                            last      = 1'b1;
                        end
                        default: orphan = 1'b1;
                    endcase
                end
                S_T6: begin
                    case (op)
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                            d_alu_out  = 1'b1;
                            d_ld_acc   = 1'b1;
                            d_ld_flags = 1'b1;
                            last       = 1'b1;
                        end
                        4'h6: begin
                            d_ld_flags = 1'b1;
                            last       = 1'b1;
                        end
                        default: orphan = 1'b1;
                    endcase
                end
                // Reserved T7..T_MAX: nothing defined there yet, recover to fetch.
                default: orphan = 1'b1;
            endcase

            if (state_q == S_T4 || state_q == S_T5 || state_q == S_T6) begin
                if (op >= 4'h1 && op <= 4'h5) begin
                    d_alu_op = op_m1[2:0];
                end else if (op == 4'h6) begin
                    d_alu_op = 3'b101;
                end
            end
        end

        stall = (d_mem_out | d_mem_wr) & ~bus.mem_rdy;

        state_d = state_q;
        halt_d  = halt_q;
        if (halt_q) begin
            state_d = state_q;
        end else if (state_q == S_WAIT) begin
            state_d = bus.step_req ? S_T1 : S_WAIT;
        end else if (stall) begin
            state_d = state_q;
        end else if (hlt_t4) begin
            halt_d = 1'b1;
        end else if (last) begin
            state_d = bus.step_mode ? S_WAIT : S_T1;
        end else if (orphan || int'(state_q) >= T_MAX) begin
            state_d = S_T1;
        end else begin
            state_d = state_t'(state_q + 1'b1);
        end

        // While reset is held the state reads T1 but every strobe is forced idle.
        en = low_clr;
        bus.inc            = en & d_inc & ~stall;
        bus.pc_out_en      = en & d_pc_out;
        bus.low_ld_mar     = ~(en & d_ld_mar & ~stall);
        bus.low_mem_out_en = ~(en & d_mem_out);
        bus.low_mem_wr     = ~(en & d_mem_wr & ~stall);
        bus.low_ld_ir      = ~(en & d_ld_ir & ~stall);
        bus.low_ir_out_en  = ~(en & d_ir_out);
        bus.low_ld_acc     = ~(en & d_ld_acc & ~stall);
        bus.acc_out_en     = en & d_acc_out;
        bus.low_ld_b_reg   = ~(en & d_ld_b & ~stall);
        bus.alu_out_en     = en & d_alu_out;
        bus.alu_op         = en ? d_alu_op : 3'b000;
        bus.low_ld_flags   = ~(en & d_ld_flags & ~stall);
        bus.low_ld_out_reg = ~(en & d_ld_out & ~stall);
        bus.low_halt       = ~halt_q;
        bus.t_state        = state_q;
        bus.instr_done     = en & last;
    end
endmodule

// File: tb/tb_sap_seq_vlen.sv
// Scoreboard bench for sap_seq_vlen: a micro-program table model predicts every cycle's outputs,
// a negedge monitor compares them and checks that at most one bus driver is active.
module tb_sap_seq_vlen;
    logic clk = 1'b0;
    logic low_clr = 1'b0;
    always #5 clk = ~clk;

    sap_seq_vlen_if #(.OPCODE_W(4), .T_W(4)) bif ();

    sap_seq_vlen #(.OPCODE_W(4), .T_MAX(6), .T_W(4)) dut (
        .clk(clk),
        .low_clr(low_clr),
        .bus(bif)
    );

    typedef struct packed {
        logic       inc;
        logic       pc_out_en;
        logic       low_ld_mar;
        logic       low_mem_out_en;
        logic       low_mem_wr;
        logic       low_ld_ir;
        logic       low_ir_out_en;
        logic       low_ld_acc;
        logic       acc_out_en;
        logic       low_ld_b_reg;
        logic       alu_out_en;
        logic [2:0] alu_op;
        logic       low_ld_flags;
        logic       low_ld_out_reg;
        logic       low_halt;
        logic [3:0] t_state;
        logic       instr_done;
    } obs_t;

    localparam int A_INC = 1, A_PC_OUT = 2, A_LD_MAR = 4, A_MEM_OUT = 8, A_MEM_WR = 16;
    localparam int A_LD_IR = 32, A_IR_OUT = 64, A_LD_ACC = 128, A_ACC_OUT = 256;
    localparam int A_LD_B = 512, A_ALU_OUT = 1024, A_LD_FLAGS = 2048, A_LD_OUT = 4096;
    localparam int LOADS = A_INC | A_LD_MAR | A_MEM_WR | A_LD_IR | A_LD_ACC | A_LD_B | A_LD_FLAGS | A_LD_OUT;

    int prog[16][7];
    int plen[16];
    int m_t = 1;
    bit m_halt = 1'b0;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    obs_t exp_q[$];
    obs_t mon_e, mon_a;
    int drivers;

    task automatic build_prog();
        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 7; t++) prog[op][t] = 0;
            prog[op][1] = A_PC_OUT | A_LD_MAR;
            prog[op][2] = A_INC;
            prog[op][3] = A_MEM_OUT | A_LD_IR;
            plen[op] = 3;
        end
        prog[0][4] = A_IR_OUT | A_LD_MAR;
        prog[0][5] = A_MEM_OUT | A_LD_ACC;
        plen[0] = 5;
        for (int op = 1; op <= 6; op++) begin
            prog[op][4] = A_IR_OUT | A_LD_MAR;
            prog[op][5] = A_MEM_OUT | A_LD_B;
            prog[op][6] = (op == 6) ? A_LD_FLAGS : (A_ALU_OUT | A_LD_ACC | A_LD_FLAGS);
            plen[op] = 6;
        end
        prog[7][4] = A_IR_OUT | A_LD_ACC;
        plen[7] = 4;
        prog[8][4] = A_IR_OUT | A_LD_MAR;
        prog[8][5] = A_ACC_OUT | A_MEM_WR;
        plen[8] = 5;
        prog[14][4] = A_ACC_OUT | A_LD_OUT;
        plen[14] = 4;
        plen[15] = 4;
    endtask

    function automatic int actions(int t, bit halted, int op, bit rdy);
        int act;
        act = 0;
        if (!halted && t >= 1 && t <= 6) act = prog[op][t];
        if ((act & (A_MEM_OUT | A_MEM_WR)) != 0 && !rdy) act = act & ~LOADS;
        return act;
    endfunction

    function automatic bit stalled(int t, bit halted, int op, bit rdy);
        return !halted && t >= 1 && t <= 6 && !rdy && ((prog[op][t] & (A_MEM_OUT | A_MEM_WR)) != 0);
    endfunction

    function automatic obs_t predict(int t, bit halted, int op, bit rdy, bit in_rst);
        obs_t o;
        int act;
        int alu;
        bit active;
        active = !in_rst && !halted && t != 0;
        act = in_rst ? 0 : actions(t, halted, op, rdy);
        alu = 0;
        if (active && t >= 4) begin
            if (op >= 1 && op <= 5) alu = op - 1;
            else if (op == 6) alu = 5;
        end
        o.inc            = (act & A_INC) != 0;
        o.pc_out_en      = (act & A_PC_OUT) != 0;
        o.low_ld_mar     = (act & A_LD_MAR) == 0;
        o.low_mem_out_en = (act & A_MEM_OUT) == 0;
        o.low_mem_wr     = (act & A_MEM_WR) == 0;
        o.low_ld_ir      = (act & A_LD_IR) == 0;
        o.low_ir_out_en  = (act & A_IR_OUT) == 0;
        o.low_ld_acc     = (act & A_LD_ACC) == 0;
        o.acc_out_en     = (act & A_ACC_OUT) != 0;
        o.low_ld_b_reg   = (act & A_LD_B) == 0;
        o.alu_out_en     = (act & A_ALU_OUT) != 0;
        o.alu_op         = alu[2:0];
        o.low_ld_flags   = (act & A_LD_FLAGS) == 0;
        o.low_ld_out_reg = (act & A_LD_OUT) == 0;
        o.low_halt       = !halted;
        o.t_state        = t[3:0];
        o.instr_done     = active && t == plen[op] && op != 15;
        return o;
    endfunction

    function automatic obs_t capture();
        obs_t a;
        a.inc            = bif.inc;
        a.pc_out_en      = bif.pc_out_en;
        a.low_ld_mar     = bif.low_ld_mar;
        a.low_mem_out_en = bif.low_mem_out_en;
        a.low_mem_wr     = bif.low_mem_wr;
        a.low_ld_ir      = bif.low_ld_ir;
        a.low_ir_out_en  = bif.low_ir_out_en;
        a.low_ld_acc     = bif.low_ld_acc;
        a.acc_out_en     = bif.acc_out_en;
        a.low_ld_b_reg   = bif.low_ld_b_reg;
        a.alu_out_en     = bif.alu_out_en;
        a.alu_op         = bif.alu_op;
        a.low_ld_flags   = bif.low_ld_flags;
        a.low_ld_out_reg = bif.low_ld_out_reg;
        a.low_halt       = bif.low_halt;
        a.t_state        = bif.t_state;
        a.instr_done     = bif.instr_done;
        return a;
    endfunction

    // One clock of stimulus: drive inputs, queue this cycle's prediction, advance the model.
    task automatic step(int op, bit rdy, bit smode, bit sreq, bit rst_n_v);
        @(posedge clk);
        #1;
        low_clr       = rst_n_v;
        bif.op_code   = op[3:0];
        bif.mem_rdy   = rdy;
        bif.step_mode = smode;
        bif.step_req  = sreq;
        if (!rst_n_v) begin
            m_t = 1;
            m_halt = 1'b0;
        end
        exp_q.push_back(predict(m_t, m_halt, op, rdy, !rst_n_v));
        if (rst_n_v && !m_halt) begin
            if (m_t == 0) begin
                if (sreq) m_t = 1;
            end else if (stalled(m_t, m_halt, op, rdy)) begin
                m_t = m_t;
            end else if (op == 15 && m_t == 4) begin
                m_halt = 1'b1;
            end else if (m_t == plen[op]) begin
                m_t = smode ? 0 : 1;
            end else begin
                m_t = m_t + 1;
            end
        end
    endtask

    task automatic reset_midcycle();
        obs_t e, a;
        @(negedge clk);
        #1;
        low_clr = 1'b0;
        #1;
        m_t = 1;
        m_halt = 1'b0;
        e = predict(1, 1'b0, 0, 1'b1, 1'b1);
        a = capture();
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL async_reset actual=%h required=%h", a, e);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = capture();
            tests++;
            if (mon_a !== mon_e) begin
                fails++;
                $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h (t_state %0d vs %0d)",
                         cyc, mon_a, mon_e, mon_a.t_state, mon_e.t_state);
            end
            drivers = int'(bif.pc_out_en) + int'(!bif.low_mem_out_en) + int'(!bif.low_ir_out_en)
                    + int'(bif.acc_out_en) + int'(bif.alu_out_en);
            tests++;
            if (drivers > 1) begin
                fails++;
                $display("FAIL bus_drivers cyc=%0d actual=%0d required<=1", cyc, drivers);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op, halt_cnt;
        bit rdy, smode, sreq;
        int stall_pat[8];
        build_prog();
        bif.op_code = 4'h0;
        bif.mem_rdy = 1'b1;
        bif.step_mode = 1'b0;
        bif.step_req = 1'b0;

        repeat (3) step(0, 1, 0, 0, 0);
        repeat (6) step(0, 1, 0, 0, 1);        // LDA: 1,2,3,4,5,1
        repeat (5) step(2, 1, 0, 0, 1);        // SUB (T1 already consumed)
        repeat (6) step(6, 1, 0, 0, 1);        // CMP
        repeat (3) step(10, 1, 0, 0, 1);       // NOP
        repeat (4) step(7, 1, 0, 0, 1);        // LDI
        repeat (5) step(8, 1, 0, 0, 1);        // STA

        stall_pat = '{1, 1, 0, 0, 0, 1, 1, 1};
        foreach (stall_pat[i]) step(0, stall_pat[i][0], 0, 0, 1);
        step(8, 1, 0, 0, 1);
        step(8, 1, 0, 0, 1);
        step(8, 1, 0, 0, 1);
        step(8, 1, 0, 0, 1);
        step(8, 0, 0, 0, 1);                   // STA write stalled in T5
        step(8, 0, 0, 0, 1);
        step(8, 1, 0, 0, 1);

        repeat (4) step(14, 1, 1, 0, 1);       // OUT with step_mode -> WAIT
        for (int i = 0; i < 10; i++) step(14, i[0], 1, 0, 1);
        step(14, 1, 1, 1, 1);
        repeat (5) step(0, 1, 0, 0, 1);        // LDA in step_mode off
        step(0, 1, 0, 1, 1);                   // step_req outside WAIT ignored

        repeat (24) step(15, $urandom_range(0, 1), 0, $urandom_range(0, 1), 1);
        reset_midcycle();
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        op = 0;
        halt_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_t == 1 || m_t == 0) begin
                op = $urandom_range(0, 15);
                if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
            end
            rdy   = ($urandom_range(0, 3) != 0);
            smode = ($urandom_range(0, 9) == 0);
            sreq  = ($urandom_range(0, 2) == 0);
            if (m_halt) halt_cnt++;
            if (halt_cnt > 5 || $urandom_range(0, 499) == 0) begin
                halt_cnt = 0;
                step(op, rdy, smode, sreq, 0);
            end else begin
                step(op, rdy, smode, sreq, 1);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
